// File: rtl/halfband_pkg.sv
// Shared types and derived constants for the folded halfband FIR sequencer.
// Constants are functions of the filter length so every instance derives its own.
package halfband_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_MAC,
        S_DUMP
    } hb_state_t;

    // MAC cycles per sample: nonzero coefficient pairs plus the centre tap
    function automatic int nm_of(input int len);
        return (len + 1) / 4 + 1;
    endfunction

    function automatic int ctr_of(input int len);
        return (len - 1) / 2;
    endfunction

endpackage

// File: rtl/halfband_tap_cnt.sv
// Tap counter for the folded halfband MAC: steps over the even (nonzero)
// pairs, then jumps to the centre tap; mirror index tracks it in lockstep.
module halfband_tap_cnt
    import halfband_pkg::*;
#(
    parameter int LENGTH = 15,
    parameter int TW     = 4
) (
    input  logic          sys_clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          step,
    output logic [TW-1:0] tap_idx,
    output logic [TW-1:0] tap_mir,
    output logic [TW-1:0] idx_nxt,
    output logic          last
);

    localparam logic [TW-1:0] CTR_V  = TW'(ctr_of(LENGTH));
    localparam logic [TW-1:0] PAIR_V = TW'(ctr_of(LENGTH) - 1);
    localparam logic [TW-1:0] MIR0   = TW'(LENGTH - 1);

    always_comb begin
        idx_nxt = tap_idx;
        if (clr) begin
            idx_nxt = '0;
        end else if (step) begin
            idx_nxt = (tap_idx == PAIR_V) ? CTR_V : tap_idx + TW'(2);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            tap_idx <= '0;
            tap_mir <= MIR0;
        end else begin
            tap_idx <= idx_nxt;
            tap_mir <= MIR0 - idx_nxt;
        end
    end

    assign last = (tap_idx == CTR_V);

endmodule

// File: rtl/halfband_mac_seq.sv
// Control sequencer for a folded single-multiplier halfband FIR with
// optional decimate-by-2; all outputs are registered.
module halfband_mac_seq
    import halfband_pkg::*;
#(
    parameter int LENGTH = 15,
    parameter int DECIM  = 1,
    parameter int TW     = 4
) (
    input  logic          sys_clk,
    input  logic          reset,
    input  logic          sam_clk_en,
    output logic          shift_en,
    output logic          acc_clr,
    output logic          acc_en,
    output logic [TW-1:0] tap_idx,
    output logic [TW-1:0] tap_mir,
    output logic          ctr_tap,
    output logic          y_load,
    output logic          busy,
    output logic          ovf
);

    if ((LENGTH % 4 != 3) || (LENGTH < 7) ||
        !((DECIM == 1) || (DECIM == 2)) ||
        ((1 << TW) < LENGTH)) begin : g_bad_param
        $error("halfband_mac_seq: illegal LENGTH/DECIM/TW");
    end

    localparam logic [TW-1:0] CTR_V = TW'(ctr_of(LENGTH));

    hb_state_t     state, state_n;
    logic          ph;
    logic          cmp;
    logic          accept;
    logic          cnt_clr;
    logic          cnt_step;
    logic          cnt_last;
    logic [TW-1:0] idx_nxt;

    logic shift_d, clr_d, en_d, ctr_d, yld_d, busy_d;

    assign accept = sam_clk_en &&
                    ((state == S_IDLE) || (state == S_DUMP));

    halfband_tap_cnt #(
        .LENGTH (LENGTH),
        .TW     (TW)
    ) u_cnt (
        .sys_clk (sys_clk),
        .reset   (reset),
        .clr     (cnt_clr),
        .step    (cnt_step),
        .tap_idx (tap_idx),
        .tap_mir (tap_mir),
        .idx_nxt (idx_nxt),
        .last    (cnt_last)
    );

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:  if (accept) state_n = S_SHIFT;
            S_SHIFT: state_n = cmp ? S_MAC : S_IDLE;
            S_MAC:   if (cnt_last) state_n = S_DUMP;
            S_DUMP:  state_n = accept ? S_SHIFT : S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    assign cnt_clr  = (state_n != S_MAC);
    assign cnt_step = (state == S_MAC);

    // Decode from the next state so the pulses land registered in that state
    always_comb begin
        shift_d = (state_n == S_SHIFT);
        en_d    = (state_n == S_MAC);
        clr_d   = (state_n == S_MAC) && (state != S_MAC);
        ctr_d   = (state_n == S_MAC) && (idx_nxt == CTR_V);
        yld_d   = (state_n == S_DUMP);
        busy_d  = (state_n != S_IDLE);
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            shift_en <= 1'b0;
            acc_clr  <= 1'b0;
            acc_en   <= 1'b0;
            ctr_tap  <= 1'b0;
            y_load   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            shift_en <= shift_d;
            acc_clr  <= clr_d;
            acc_en   <= en_d;
            ctr_tap  <= ctr_d;
            y_load   <= yld_d;
            busy     <= busy_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            ph  <= 1'b0;
            cmp <= 1'b0;
            ovf <= 1'b0;
        end else begin
            if (accept) begin
                cmp <= (DECIM == 1) || !ph;
                if (DECIM == 2) ph <= !ph;
            end
            if (sam_clk_en && ((state == S_SHIFT) || (state == S_MAC)))
                ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_halfband_mac_seq.sv
// Bench for halfband_mac_seq: three instances (L15/D1, L15/D2, L11/D1)
// checked every cycle against a timeline model plus literal expectations.
module tb_halfband_mac_seq;

    logic sys_clk = 1'b0;
    logic reset;
    logic sam;

    always #5 sys_clk = ~sys_clk;

    logic        se  [3];
    logic        ac  [3];
    logic        ae  [3];
    logic        ct  [3];
    logic        yl  [3];
    logic        bz  [3];
    logic        ov  [3];
    logic [3:0]  ti  [3];
    logic [3:0]  tm  [3];

    halfband_mac_seq #(.LENGTH(15), .DECIM(1), .TW(4)) dut0 (
        .sys_clk(sys_clk), .reset(reset), .sam_clk_en(sam),
        .shift_en(se[0]), .acc_clr(ac[0]), .acc_en(ae[0]),
        .tap_idx(ti[0]), .tap_mir(tm[0]), .ctr_tap(ct[0]),
        .y_load(yl[0]), .busy(bz[0]), .ovf(ov[0]));

    halfband_mac_seq #(.LENGTH(15), .DECIM(2), .TW(4)) dut1 (
        .sys_clk(sys_clk), .reset(reset), .sam_clk_en(sam),
        .shift_en(se[1]), .acc_clr(ac[1]), .acc_en(ae[1]),
        .tap_idx(ti[1]), .tap_mir(tm[1]), .ctr_tap(ct[1]),
        .y_load(yl[1]), .busy(bz[1]), .ovf(ov[1]));

    halfband_mac_seq #(.LENGTH(11), .DECIM(1), .TW(4)) dut2 (
        .sys_clk(sys_clk), .reset(reset), .sam_clk_en(sam),
        .shift_en(se[2]), .acc_clr(ac[2]), .acc_en(ae[2]),
        .tap_idx(ti[2]), .tap_mir(tm[2]), .ctr_tap(ct[2]),
        .y_load(yl[2]), .busy(bz[2]), .ovf(ov[2]));

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    bit started = 1'b0;

    int t0   [3];
    bit cmpf [3];
    bit phm  [3];
    bit ovfm [3];
    int ycnt [3];
    int ylast[3];

    function automatic int len_of(input int i);
        return (i == 2) ? 11 : 15;
    endfunction

    function automatic int dec_of(input int i);
        return (i == 1) ? 2 : 1;
    endfunction

    function automatic int nm_len(input int len);
        return (len + 1) / 4 + 1;
    endfunction

    // Expected outputs from the time elapsed since the last accepted strobe
    function automatic logic [14:0] expect_of(input int i, input int c);
        int len, nm, ctr, d, k, idx;
        logic e_se, e_ac, e_ae, e_ct, e_yl, e_bz;
        len = len_of(i);
        nm  = nm_len(len);
        ctr = (len - 1) / 2;
        d   = c - t0[i];
        idx = 0;
        e_se = (d == 1);
        e_ac = 1'b0;
        e_ae = 1'b0;
        e_ct = 1'b0;
        e_yl = 1'b0;
        e_bz = (d == 1);
        if (cmpf[i]) begin
            if (d >= 2 && d <= 1 + nm) begin
                k    = d - 2;
                e_ae = 1'b1;
                e_ac = (k == 0);
                e_ct = (k == nm - 1);
                idx  = e_ct ? ctr : 2 * k;
            end
            e_yl = (d == 2 + nm);
            e_bz = (d >= 1) && (d <= 2 + nm);
        end
        return {e_se, e_ac, e_ae, e_ct, e_yl, e_bz, ovfm[i],
                4'(idx), 4'(len - 1 - idx)};
    endfunction

    always @(posedge sys_clk) begin
        int p, nm;
        bit acc;
        p = cyc;
        for (int i = 0; i < 3; i++) begin
            nm = nm_len(len_of(i));
            if (reset) begin
                t0[i]   = -1000;
                cmpf[i] = 1'b0;
                phm[i]  = 1'b0;
                ovfm[i] = 1'b0;
            end else if (sam) begin
                acc = cmpf[i] ? (p >= t0[i] + 2 + nm) : (p >= t0[i] + 2);
                if (acc) begin
                    t0[i]   = p;
                    cmpf[i] = (dec_of(i) == 1) || !phm[i];
                    if (dec_of(i) == 2) phm[i] = !phm[i];
                end else begin
                    ovfm[i] = 1'b1;
                end
            end
        end
        if (reset) started = 1'b1;
        cyc = p + 1;
    end

    always @(negedge sys_clk) begin
        logic [14:0] obs, exp;
        if (started) begin
            for (int i = 0; i < 3; i++) begin
                obs = {se[i], ac[i], ae[i], ct[i], yl[i], bz[i], ov[i],
                       ti[i], tm[i]};
                exp = expect_of(i, cyc);
                n_cmp++;
                if (obs !== exp) begin
                    n_bad++;
                    $display("FAIL cyc%0d inst%0d outputs: got %b want %b",
                             cyc, i, obs, exp);
                end
                if (yl[i] === 1'b1) begin
                    ycnt[i]++;
                    ylast[i] = cyc;
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    task automatic pulse(input logic s, input logic r);
        sam   = s;
        reset = r;
        @(posedge sys_clk);
        #1;
        sam   = 1'b0;
        reset = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic zero_counts();
        for (int i = 0; i < 3; i++) begin
            ycnt[i]  = 0;
            ylast[i] = -1;
        end
    endtask

    initial begin
        int t;
        sam   = 1'b0;
        reset = 1'b1;
        zero_counts();
        repeat (3) @(posedge sys_clk);
        #1;
        reset = 1'b0;
        idle(5);

        // single strobe
        zero_counts();
        t = cyc;
        pulse(1'b1, 1'b0);
        idle(14);
        check("single_l15_count", ycnt[0], 1);
        check("single_l15_yload", ylast[0], t + 7);
        check("single_d2_yload", ylast[1], t + 7);
        check("single_l11_count", ycnt[2], 1);
        check("single_l11_yload", ylast[2], t + 6);

        // back-to-back at the minimum period
        zero_counts();
        for (int n = 0; n < 20; n++) begin
            t = cyc;
            pulse(1'b1, 1'b0);
            idle(6);
        end
        idle(10);
        check("period_l15_count", ycnt[0], 20);
        check("period_l15_last", ylast[0], t + 7);
        check("period_d2_count", ycnt[1], 10);
        check("period_l11_count", ycnt[2], 20);
        check("period_l15_ovf", int'(ov[0]), 0);

        // strobe dropped mid-compute
        zero_counts();
        t = cyc;
        pulse(1'b1, 1'b0);
        idle(2);
        pulse(1'b1, 1'b0);
        idle(12);
        check("drop_l15_ovf", int'(ov[0]), 1);
        check("drop_l15_count", ycnt[0], 1);
        check("drop_l15_yload", ylast[0], t + 7);
        check("drop_l11_ovf", int'(ov[2]), 1);

        // decimate-by-2 from a fresh reset
        pulse(1'b0, 1'b1);
        idle(3);
        check("reset_clears_ovf", int'(ov[0]), 0);
        zero_counts();
        t = cyc;
        for (int n = 0; n < 4; n++) begin
            pulse(1'b1, 1'b0);
            idle(9);
        end
        idle(5);
        check("dec2_count", ycnt[1], 2);
        check("dec2_last", ylast[1], t + 27);
        check("dec1_count", ycnt[0], 4);

        // reset mid-MAC, then a clean sample
        zero_counts();
        t = cyc;
        pulse(1'b1, 1'b0);
        idle(3);
        pulse(1'b0, 1'b1);
        idle(5);
        pulse(1'b1, 1'b0);
        idle(12);
        check("abort_l15_count", ycnt[0], 1);
        check("abort_l15_yload", ylast[0], t + 17);
        check("abort_d2_count", ycnt[1], 1);
        check("abort_d2_yload", ylast[1], t + 17);

        idle(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
